// File: rtl/fitbit_pkg.sv
// Shared widths, defaults and types for the fitness-tracker pipeline.
// Imported by step_rate_meter, sec_timebase and the display stage.
package fitbit_pkg;

  localparam int unsigned STEP_W = 20;
  localparam int unsigned RATE_W = 8;
  localparam int unsigned RUN_W  = 16;

  localparam int unsigned DEF_SEC_CYCLES = 100000000;
  localparam int unsigned DEF_HI_THRESH  = 32;

  typedef enum logic {
    WINDOW,
    DONE
  } win_state_e;

  // Clamp a wide step sum to the 8-bit rate range.
  function automatic logic [RATE_W-1:0] sat_rate(input logic [STEP_W:0] v);
    return (v > (STEP_W+1)'(255)) ? '1 : v[RATE_W-1:0];
  endfunction

endpackage

// File: rtl/sec_timebase.sv
// One-second tick generator: counts 0..SEC_CYCLES-1 while enabled, tick on the last count.
module sec_timebase
  import fitbit_pkg::*;
#(
  parameter int unsigned SEC_CYCLES = DEF_SEC_CYCLES
) (
  input  logic clk100MHz,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(SEC_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (enable) begin
      if (timer_q == LAST) begin
        tick    = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_d;
  end

endmodule

// File: rtl/step_rate_meter.sv
// Per-second step rate, high-activity window count and active-run tracking.
// Optional 4-second average output enabled by defining STEP_RATE_AVG_EN.
module step_rate_meter
  import fitbit_pkg::*;
#(
  parameter int unsigned SEC_CYCLES = DEF_SEC_CYCLES,
  parameter int unsigned WINDOW_SEC = 9,
  parameter int unsigned HI_THRESH  = DEF_HI_THRESH,
  parameter int unsigned ACTIVE_MIN = 1
) (
  input  logic              clk100MHz,
  input  logic              reset,
  input  logic [STEP_W-1:0] step_count,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic [3:0]        hi_secs,
  output logic              win_done,
  output logic [RUN_W-1:0]  cur_run,
  output logic [RUN_W-1:0]  max_run
`ifdef STEP_RATE_AVG_EN
  ,
  output logic [RATE_W-1:0] avg_rate
`endif
);

  logic              primed_q;
  logic [STEP_W-1:0] prev_q;
  logic [RATE_W-1:0] sec_acc_q, sec_acc_d;
  logic [RATE_W-1:0] rate_q;
  logic              rate_valid_q;
  logic [3:0]        hi_q, hi_d;
  logic [15:0]       sec_idx_q, sec_idx_d;
  logic [RUN_W-1:0]  cur_q, cur_d, max_q, max_d, cur_inc;
  win_state_e        state_q, state_d;

  logic              tick;
  logic [STEP_W-1:0] delta;
  logic [STEP_W:0]   acc_sum;
  logic [RATE_W-1:0] closing_rate;
  logic              is_high, is_active, in_window;

  sec_timebase #(.SEC_CYCLES(SEC_CYCLES)) u_timebase (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .enable    (primed_q),
    .tick      (tick)
  );

  // Modulo subtraction makes the 0xFFFFF -> 0x00000 wrap count as one step.
  assign delta        = step_count - prev_q;
  assign acc_sum      = {1'b0, delta} + (STEP_W+1)'(sec_acc_q);
  assign closing_rate = sat_rate(acc_sum);
  assign is_high      = int'(closing_rate) > int'(HI_THRESH);
  assign is_active    = int'(closing_rate) >= int'(ACTIVE_MIN);
  assign in_window    = int'(sec_idx_q) < int'(WINDOW_SEC);
  assign cur_inc      = (cur_q == '1) ? cur_q : cur_q + 1'b1;

  always_comb begin
    sec_acc_d = sec_acc_q;
    if (tick)          sec_acc_d = '0;
    else if (primed_q) sec_acc_d = closing_rate;
  end

  // Window FSM: state register / next state / outputs.
  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) state_q <= WINDOW;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WINDOW:  if (tick && (int'(sec_idx_q) + 1 >= int'(WINDOW_SEC))) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = WINDOW;
    endcase
  end

  always_comb begin
    win_done = (state_q == DONE);
  end

  always_comb begin
    hi_d      = hi_q;
    sec_idx_d = sec_idx_q;
    if (tick && state_q == WINDOW) begin
      sec_idx_d = sec_idx_q + 1'b1;
      if (in_window && is_high && hi_q != 4'hF) hi_d = hi_q + 1'b1;
    end
  end

  always_comb begin
    cur_d = cur_q;
    max_d = max_q;
    if (tick) begin
      if (is_active) begin
        cur_d = cur_inc;
        max_d = (cur_inc > max_q) ? cur_inc : max_q;
      end else begin
        cur_d = '0;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      primed_q     <= 1'b0;
      prev_q       <= '0;
      sec_acc_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      hi_q         <= '0;
      sec_idx_q    <= '0;
      cur_q        <= '0;
      max_q        <= '0;
    end else begin
      primed_q     <= 1'b1;
      prev_q       <= step_count;
      sec_acc_q    <= sec_acc_d;
      rate_valid_q <= tick;
      if (tick) rate_q <= closing_rate;
      hi_q         <= hi_d;
      sec_idx_q    <= sec_idx_d;
      cur_q        <= cur_d;
      max_q        <= max_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign hi_secs    = hi_q;
  assign cur_run    = cur_q;
  assign max_run    = max_q;

`ifdef STEP_RATE_AVG_EN
  logic [RATE_W-1:0] hist_q [3];
  logic [RATE_W-1:0] avg_q;
  logic [RATE_W+1:0] avg_sum;

  assign avg_sum = (RATE_W+2)'(closing_rate) + (RATE_W+2)'(hist_q[0])
                 + (RATE_W+2)'(hist_q[1]) + (RATE_W+2)'(hist_q[2]);

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) hist_q[i] <= '0;
      avg_q <= '0;
    end else if (tick) begin
      hist_q[0] <= closing_rate;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      avg_q     <= avg_sum[RATE_W+1:2];
    end
  end

  assign avg_rate = avg_q;
`endif

endmodule

// File: tb/tb_step_rate_meter.sv
// Directed, table-driven bench for step_rate_meter with a 100-cycle second.
module tb_step_rate_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] step_count;

  logic [7:0]  rate, rate0;
  logic        rate_valid, rate_valid0;
  logic [3:0]  hi_secs, hi_secs0;
  logic        win_done, win_done0;
  logic [15:0] cur_run, cur_run0, max_run, max_run0;
`ifdef STEP_RATE_AVG_EN
  logic [7:0]  avg_rate, avg_rate0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  step_rate_meter #(.SEC_CYCLES(100), .WINDOW_SEC(9), .HI_THRESH(32), .ACTIVE_MIN(1)) u_dut (
    .clk100MHz  (clk),
    .reset      (reset),
    .step_count (step_count),
    .rate       (rate),
    .rate_valid (rate_valid),
    .hi_secs    (hi_secs),
    .win_done   (win_done),
    .cur_run    (cur_run),
    .max_run    (max_run)
`ifdef STEP_RATE_AVG_EN
    ,
    .avg_rate   (avg_rate)
`endif
  );

  // Zero-length window instance shares the same stimulus.
  step_rate_meter #(.SEC_CYCLES(100), .WINDOW_SEC(0), .HI_THRESH(32), .ACTIVE_MIN(1)) u_dut0 (
    .clk100MHz  (clk),
    .reset      (reset),
    .step_count (step_count),
    .rate       (rate0),
    .rate_valid (rate_valid0),
    .hi_secs    (hi_secs0),
    .win_done   (win_done0),
    .cur_run    (cur_run0),
    .max_run    (max_run0)
`ifdef STEP_RATE_AVG_EN
    ,
    .avg_rate   (avg_rate0)
`endif
  );

  typedef struct {
    bit          rst;
    logic [19:0] init;
    int          n;
    int          inc;
    bit          bnd;
    int          rate;
    int          hi;
    int          done;
    int          cur;
    int          mx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [19:0] init, int n, int inc, bit bnd,
                              int r, int hi, int done, int cur, int mx);
    vec_t v;
    v.rst = rst; v.init = init; v.n = n; v.inc = inc; v.bnd = bnd;
    v.rate = r; v.hi = hi; v.done = done; v.cur = cur; v.mx = mx;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [19:0] init);
    @(negedge clk);
    reset      = 1'b0;
    step_count = init;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the negedge of a second's first cycle; leaves at the next second's first cycle.
  task automatic run_second(input int n, input int inc, input bit bnd);
    bit stray = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0 && rate_valid !== 1'b0) stray = 1'b1;
      if (c < n) step_count = step_count + 20'(inc);
      if (c == 99 && bnd) step_count = step_count + 20'd1;
      @(negedge clk);
    end
    chk("rate_valid_single", int'(stray), 0);
    chk("rate_valid_pulse", int'(rate_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    step_count = 20'd500;
    repeat (2) @(negedge clk);
    chk("rst_rate", int'(rate), 0);
    chk("rst_valid", int'(rate_valid), 0);
    chk("rst_hi", int'(hi_secs), 0);
    chk("rst_done", int'(win_done), 0);
    chk("rst_cur", int'(cur_run), 0);
    chk("rst_max", int'(max_run), 0);

    // Phase A: mixed rates across the window.
    tbl.push_back(mk(1, 20'd500, 0,   0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,       40,  1, 0,  40, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0,       32,  1, 0,  32, 1, 0, 2, 2));
    tbl.push_back(mk(0, 0,       0,   0, 1,   1, 1, 0, 3, 3));
    tbl.push_back(mk(0, 0,       0,   0, 0,   0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0,       100, 3, 0, 255, 2, 0, 1, 3));
    tbl.push_back(mk(0, 0,       40,  1, 0,  40, 3, 0, 2, 3));
    tbl.push_back(mk(0, 0,       40,  1, 0,  40, 4, 0, 3, 3));
    tbl.push_back(mk(0, 0,       40,  1, 0,  40, 5, 1, 4, 4));
    tbl.push_back(mk(0, 0,       40,  1, 0,  40, 5, 1, 5, 5));
    // Wrap of the 20-bit count, primed on a nonzero value.
    tbl.push_back(mk(1, 20'hFFFFE, 3, 1, 0,   3, 0, 0, 1, 1));
    // Runs: 5,5,0,5,5,5.
    tbl.push_back(mk(1, 20'd0, 5, 1, 0, 5, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0,     5, 1, 0, 5, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0,     5, 1, 0, 5, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0,     5, 1, 0, 5, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0,     5, 1, 0, 5, 0, 0, 3, 3));
    // Ten seconds at 40: window closes after the ninth.
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(k == 1, 20'd0, 40, 1, 0, 40, (k < 9) ? k : 9, (k >= 9) ? 1 : 0, k, k));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].init);
      run_second(tbl[i].n, tbl[i].inc, tbl[i].bnd);
      chk($sformatf("rate[%0d]", i), int'(rate), tbl[i].rate);
      chk($sformatf("hi_secs[%0d]", i), int'(hi_secs), tbl[i].hi);
      chk($sformatf("win_done[%0d]", i), int'(win_done), tbl[i].done);
      chk($sformatf("cur_run[%0d]", i), int'(cur_run), tbl[i].cur);
      chk($sformatf("max_run[%0d]", i), int'(max_run), tbl[i].mx);
      chk($sformatf("w0_done[%0d]", i), int'(win_done0), 1);
      chk($sformatf("w0_hi[%0d]", i), int'(hi_secs0), 0);
    end

    // Asynchronous reset in the middle of a second.
    for (int c = 0; c < 50; c++) begin
      step_count = step_count + 20'd1;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    chk("async_rate", int'(rate), 0);
    chk("async_valid", int'(rate_valid), 0);
    chk("async_hi", int'(hi_secs), 0);
    chk("async_done", int'(win_done), 0);
    chk("async_cur", int'(cur_run), 0);
    chk("async_max", int'(max_run), 0);
    step_count = 20'd777;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_second(2, 1, 0);
    chk("reprime_rate", int'(rate), 2);
    chk("reprime_hi", int'(hi_secs), 0);
    chk("reprime_cur", int'(cur_run), 1);
    chk("reprime_max", int'(max_run), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_rate_meter.md
Name: step_rate_meter

Overview:
- Downstream consumer of the 20-bit step count produced by the step-counter stage.
- Converts the running count into a per-second step rate on a 1 s timebase derived from clk100MHz.
- Tracks how many seconds in the first WINDOW_SEC seconds after reset exceeded a high-activity threshold.
- Tracks the current and longest run of consecutive active seconds.
- Outputs feed the display/mux stage.

Parameters:
SEC_CYCLES, 100000000, clock cycles per measurement second (benches override, e.g. 100)
WINDOW_SEC, 9, length in seconds of the high-activity observation window after reset
HI_THRESH, 32, rate strictly greater than this marks a high-activity second
ACTIVE_MIN, 1, rate greater than or equal to this marks an active second (run tracking)

Ports:
clk100MHz  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset; all state clears while low
step_count  in  20  monotonic step count from upstream counter, modulo 2^20
rate  out  8  steps counted in last completed second, saturates at 255
rate_valid  out  1  one-cycle pulse on the cycle rate updates
hi_secs  out  4  number of high-activity seconds within the window, saturates at 15
win_done  out  1  high once WINDOW_SEC seconds have completed; sticky until reset
cur_run  out  16  current consecutive active seconds, saturates at 65535
max_run  out  16  longest run since reset, saturates at 65535

Behaviour:
- Reset (reset low, async): rate=0, rate_valid=0, hi_secs=0, win_done=0, cur_run=0, max_run=0, timer=0, sec_acc=0, sec_idx=0, primed=0.
- Priming:
  - First clock after reset deassertion loads prev_count <= step_count, sets primed=1, accumulates nothing.
  - A nonzero upstream count at reset release is never counted as steps.
- Delta: delta = step_count - prev_count, 20-bit modulo subtraction, so 0xFFFFF->0x00000 yields 1.
  - prev_count <= step_count every primed cycle.
  - sec_acc accumulates delta, saturating at 255.
- Timebase: timer counts 0..SEC_CYCLES-1 from the primed cycle and wraps. Boundary cycle = timer==SEC_CYCLES-1.
- Boundary cycle actions, registered, visible the next cycle:
  - rate <= sat255(sec_acc + delta). A step arriving on the boundary cycle belongs to the closing second.
  - sec_acc <= 0.
  - rate_valid pulses for exactly one cycle.
- Window state machine:
  - WINDOW: on each boundary, sec_idx++. If the closing rate > HI_THRESH, hi_secs++ (saturating at 15). When sec_idx reaches WINDOW_SEC, go to DONE and set win_done=1.
  - DONE: hi_secs frozen; win_done held at 1; leaves only via reset.
  - WINDOW_SEC=0 enters DONE on the first boundary with hi_secs=0.
- Run tracking, on every boundary in both states:
  - If closing rate >= ACTIVE_MIN: cur_run++ (saturating) and max_run <= max(max_run, new cur_run) in the same update. Otherwise cur_run <= 0.
- Rate exactly equal to HI_THRESH is not high.
- Reset mid-second discards the partial second; rate goes to 0 immediately on assertion.
- Latency: step_count change to its contribution in rate is at most SEC_CYCLES+1 cycles.

Optional Feature:
- Macro STEP_RATE_AVG_EN.
- Defined:
  - Adds output avg_rate[7:0]: mean of the last 4 completed-second rates, computed as sum >> 2, truncating.
  - Seconds not yet elapsed since reset count as 0 in the mean.
  - Updates on the same cycle as rate; reset value 0.
- Undefined: port and the 4-entry history are absent; all other behaviour is identical.

Decomposition:
- Shared package fitbit_pkg:
  - STEP_W=20, RATE_W=8, RUN_W=16.
  - Window state enum {WINDOW, DONE}.
  - Default SEC_CYCLES and HI_THRESH constants, shared with the display stage.
- One sub-module, sec_timebase:
  - Parameterised by SEC_CYCLES.
  - Inputs clk100MHz, reset, enable (=primed).
  - Output tick, high on the boundary cycle.
- Rate accumulation, window FSM and run tracking stay in step_rate_meter.

Test Plan (SEC_CYCLES=100, WINDOW_SEC=9, HI_THRESH=32):
- Reset release with step_count=500 held constant -> after first boundary, rate=0 and rate_valid pulses once; no phantom 500 steps.
- step_count increments by 1 on 40 cycles within second 1 -> rate=40, hi_secs=1. Then 32 steps in second 2 -> rate=32, hi_secs stays 1.
- step_count increments on the boundary cycle itself -> that step is included in the closing second's rate, not in the next.
- step_count steps from 0xFFFFE to 0x00001 across 3 increments -> rate=3.
- 300 increments in one second -> rate=255. Nine seconds each at rate 40, then a tenth at 40 -> hi_secs=9, win_done=1 after the ninth boundary, hi_secs unchanged after the tenth.
- Active seconds with rates 5,5,0,5,5,5 -> cur_run=3, max_run=3. Assert reset mid-second -> all outputs 0 asynchronously; after release, priming re-occurs.
